// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared state encoding, golden truth tables and mismatch helper
// for the gate sweep sequencer.
package gate_sweep_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_e;

    localparam int         NUM_VECTORS = 8;
    // x = (A&B)|~C and y = ~C over vectors {C,B,A} = 0..7
    localparam logic [7:0] GOLDEN_X    = 8'h8F;
    localparam logic [7:0] GOLDEN_Y    = 8'h0F;

    function automatic logic mismatch(logic [2:0] v, logic x, logic y);
        return (x != GOLDEN_X[v]) | (y != GOLDEN_Y[v]);
    endfunction

endpackage

// File: rtl/gate_sweep_settle_cnt.sv
// gate_sweep_settle_cnt: loadable settle down-counter; expire flags a count of zero.
module gate_sweep_settle_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       expire
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= 4'd0;
        else if (load)
            cnt_q <= load_val;
        else if (cnt_q != 4'd0)
            cnt_q <= cnt_q - 4'd1;
    end

    assign expire = (cnt_q == 4'd0);

endmodule

// File: rtl/gate_sweep_sequencer.sv
// gate_sweep_sequencer: truth-table sweep controller for the 3-input gate datapath.
// Define GATE_SWEEP_GOLDEN_CHECK_EN to enable the golden comparison (pass/err_cnt).
module gate_sweep_sequencer
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [2:0] abc,
    input  logic       x_in,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] x_table,
    output logic [7:0] y_table,
    output logic       pass,
    output logic [3:0] err_cnt
);

`ifdef GATE_SWEEP_GOLDEN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    state_e     state_q;
    logic [2:0] vec_q, abc_q;
    logic       busy_q, done_q, pass_q;
    logic [7:0] x_tab_q, y_tab_q;
    logic [3:0] err_q, err_d;
    logic       expire;

    // Counter reloads whenever we are not settling, so each APPLY starts fresh
    gate_sweep_settle_cnt u_settle (
        .clk     (clk),
        .rst     (rst),
        .load    (state_q != APPLY),
        .load_val(4'(SETTLE_CYCLES - 1)),
        .expire  (expire)
    );

    // At most eight increments per sweep, so the 4-bit count cannot overflow
    assign err_d = err_q + {3'd0, CHECK_EN & mismatch(vec_q, x_in, y_in)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 3'd0;
            abc_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            x_tab_q <= 8'd0;
            y_tab_q <= 8'd0;
            err_q   <= 4'd0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q == APPLY || state_q == SAMPLE)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                pass_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start && !abort) begin
                        state_q <= APPLY;
                        vec_q   <= 3'd0;
                        abc_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        err_q   <= 4'd0;
                        pass_q  <= 1'b0;
                    end
                    APPLY: if (expire) state_q <= SAMPLE;
                    SAMPLE: begin
                        x_tab_q[vec_q] <= x_in;
                        y_tab_q[vec_q] <= y_in;
                        err_q          <= err_d;
                        if (vec_q == 3'(NUM_VECTORS - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            vec_q   <= vec_q + 3'd1;
                            abc_q   <= vec_q + 3'd1;
                            state_q <= APPLY;
                        end
                    end
                    default: begin
                        done_q  <= 1'b1;
                        pass_q  <= CHECK_EN && (err_q == 4'd0);
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign abc     = abc_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign x_table = x_tab_q;
    assign y_table = y_tab_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;

endmodule
